// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage: valid/ready in, decoded bundle out, saturating counters.
// Optional one-entry skid buffer with a registered in_ready when RV_DECODE_SKID_EN is defined.
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_class,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [4:0] C_LOAD      = 5'b00000;
    localparam logic [4:0] C_MISC_MEM  = 5'b00011;
    localparam logic [4:0] C_OP_IMM    = 5'b00100;
    localparam logic [4:0] C_AUIPC     = 5'b00101;
    localparam logic [4:0] C_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] C_STORE     = 5'b01000;
    localparam logic [4:0] C_OP        = 5'b01100;
    localparam logic [4:0] C_LUI       = 5'b01101;
    localparam logic [4:0] C_OP_32     = 5'b01110;
    localparam logic [4:0] C_BRANCH    = 5'b11000;
    localparam logic [4:0] C_JALR      = 5'b11001;
    localparam logic [4:0] C_JAL       = 5'b11011;
    localparam logic [4:0] C_SYSTEM    = 5'b11100;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    logic            out_xfer;
    logic            in_xfer;
    logic            load_out;
    logic [31:0]     dec_inst;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    assign out_xfer = out_valid & out_ready;
    assign in_xfer  = in_valid & in_ready;

`ifdef RV_DECODE_SKID_EN
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic        in_ready_q;

    assign in_ready = in_ready_q;
    assign dec_inst = skid_valid ? skid_inst : in_inst;
    // While the skid entry is full in_ready is low, so only the skid can feed the output.
    assign load_out = !flush && (skid_valid ? out_xfer
                                            : (in_xfer && (!out_valid || out_ready)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (skid_valid) begin
            if (out_xfer) begin
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (in_xfer && out_valid && !out_ready) begin
            skid_valid <= 1'b1;
            skid_inst  <= in_inst;
            in_ready_q <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign dec_inst = in_inst;
    assign load_out = !flush && in_xfer;
`endif

    always_comb begin
        dec_fmt = FMT_NONE;
        case (dec_inst[6:2])
            C_LOAD, C_MISC_MEM, C_OP_IMM, C_JALR, C_SYSTEM: dec_fmt = FMT_I;
            C_STORE:        dec_fmt = FMT_S;
            C_OP:           dec_fmt = FMT_R;
            C_LUI, C_AUIPC: dec_fmt = FMT_U;
            C_BRANCH:       dec_fmt = FMT_B;
            C_JAL:          dec_fmt = FMT_J;
            C_OP_IMM_32:    dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            C_OP_32:        dec_fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            default:        dec_fmt = FMT_NONE;
        endcase
        dec_illegal = (dec_inst[1:0] != 2'b11) || (dec_fmt == FMT_NONE);
        if (dec_illegal) begin
            dec_fmt = FMT_NONE;
        end

        // U-type folds inst[31] into the replication so the count stays nonzero at XLEN=32.
        case (dec_fmt)
            FMT_I: dec_imm = {{(XLEN-12){dec_inst[31]}}, dec_inst[31:20]};
            FMT_S: dec_imm = {{(XLEN-12){dec_inst[31]}}, dec_inst[31:25], dec_inst[11:7]};
            FMT_B: dec_imm = {{(XLEN-12){dec_inst[31]}}, dec_inst[7], dec_inst[30:25],
                              dec_inst[11:8], 1'b0};
            FMT_U: dec_imm = {{(XLEN-31){dec_inst[31]}}, dec_inst[30:12], 12'b0};
            FMT_J: dec_imm = {{(XLEN-20){dec_inst[31]}}, dec_inst[19:12], dec_inst[20],
                              dec_inst[30:21], 1'b0};
            default: dec_imm = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_class   <= '0;
            out_fmt     <= FMT_NONE;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else if (load_out) begin
            out_class   <= dec_inst[6:2];
            out_fmt     <= dec_fmt;
            out_rd      <= dec_inst[11:7];
            out_rs1     <= dec_inst[19:15];
            out_rs2     <= dec_inst[24:20];
            out_funct3  <= dec_inst[14:12];
            out_funct7  <= dec_inst[31:25];
            out_imm     <= dec_imm;
            out_illegal <= dec_illegal;
        end
    end

    // A flushed cycle never counts as an output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_decoded <= '0;
            cnt_illegal <= '0;
        end else if (out_xfer && !flush) begin
            if (cnt_decoded != '1) begin
                cnt_decoded <= cnt_decoded + CNT_W'(1);
            end
            if (out_illegal && (cnt_illegal != '1)) begin
                cnt_illegal <= cnt_illegal + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: driver pushes model predictions on accept,
// an independent negedge monitor compares and pops on output transfers.
module tb_rv_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_inst = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       out_class;
    logic [2:0]       out_fmt;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] cnt_decoded, cnt_illegal;

    rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_fmt(out_fmt),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_illegal(out_illegal),
        .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     inst;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] imm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_dec = 0;
    int   mdl_ill = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Immediates are rebuilt as weighted sums of bit fields, with inst[31] as a negative weight.
    function automatic exp_t model(input logic [31:0] w);
        exp_t   e;
        int     fmt;
        longint v;
        case (int'(w[6:2]))
            0, 3, 4, 25, 28: fmt = 1;
            8:               fmt = 2;
            12:              fmt = 0;
            5, 13:           fmt = 4;
            24:              fmt = 3;
            27:              fmt = 5;
            6:               fmt = (XLEN == 64) ? 1 : 7;
            14:              fmt = (XLEN == 64) ? 0 : 7;
            default:         fmt = 7;
        endcase
        e.ill = (w[1:0] != 2'b11) || (fmt == 7);
        if (e.ill) fmt = 7;
        case (fmt)
            1: v = longint'(w[30:20]) - (w[31] ? 2048 : 0);
            2: v = longint'(w[11:7]) + longint'(w[30:25]) * 32 - (w[31] ? 2048 : 0);
            3: v = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048
                   - (w[31] ? 4096 : 0);
            4: v = longint'(w[30:12]) * 4096 - (w[31] ? (longint'(1) << 31) : 0);
            5: v = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048 + longint'(w[19:12]) * 4096
                   - (w[31] ? (longint'(1) << 20) : 0);
            default: v = 0;
        endcase
        e.inst = w;
        e.fmt  = 3'(fmt);
        e.imm  = v[XLEN-1:0];
        return e;
    endfunction

    // Monitor: compare on every cycle the DUT presents data, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        logic exp_ready;
        if (!rst_n) begin
            sb.delete();
            mdl_dec = 0;
            mdl_ill = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_fmt", out_fmt, 7);
            check("rst_fields", {out_class, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                                 out_illegal}, 0);
            check("rst_imm", out_imm, 0);
            check("rst_cnt", {cnt_decoded, cnt_illegal}, 0);
        end else begin
`ifdef RV_DECODE_SKID_EN
            exp_ready = sb.size() < 2;
`else
            exp_ready = (sb.size() == 0) || out_ready;
`endif
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, sb.size() != 0);
            check("cnt_decoded", cnt_decoded, mdl_dec);
            check("cnt_illegal", cnt_illegal, mdl_ill);
            if (out_valid && sb.size() > 0) begin
                e = sb[0];
                check("class", out_class, e.inst[6:2]);
                check("fmt", out_fmt, e.fmt);
                check("rd", out_rd, e.inst[11:7]);
                check("rs1", out_rs1, e.inst[19:15]);
                check("rs2", out_rs2, e.inst[24:20]);
                check("funct3", out_funct3, e.inst[14:12]);
                check("funct7", out_funct7, e.inst[31:25]);
                check("imm", out_imm, e.imm);
                check("illegal", out_illegal, e.ill);
            end
            if (flush) begin
                sb.delete();
            end else if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                if (mdl_dec < CMAX) mdl_dec++;
                if (e.ill && mdl_ill < CMAX) mdl_ill++;
            end
        end
    end

    // Advance one cycle; on an accepted input push its prediction after the capturing edge.
    task automatic cycle();
        logic        acc;
        logic [31:0] w;
        #3;
        acc = in_valid && in_ready && !flush && rst_n;
        w   = in_inst;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(model(w));
    endtask

    task automatic offer(input logic [31:0] w);
        in_valid = 1'b1;
        in_inst  = w;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [4:0]  cls [0:12];
        cls = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h0C,
                5'h0D, 5'h0E, 5'h18, 5'h19, 5'h1B, 5'h1C};
        r = $urandom;
        if ($urandom_range(3) != 0) r[1:0] = 2'b11;
        if ($urandom_range(3) != 0) r[6:2] = cls[$urandom_range(12)];
        return r;
    endfunction

    logic [31:0] stream [0:3];
    int          idx;
    int          snap_dec, snap_ill;

    initial begin
        @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Directed decodes, full throughput.
        offer(32'h00500093);
        check("addi_class", out_class, 5'b00100);
        check("addi_fmt", out_fmt, 1);
        check("addi_rd_rs1", {out_rd, out_rs1}, {5'd1, 5'd0});
        check("addi_imm", out_imm, 5);
        check("addi_illegal", out_illegal, 0);
        offer(32'hFE20AE23);
        check("addi_cnt", cnt_decoded, 1);
        check("sw_fmt", out_fmt, 2);
        check("sw_regs", {out_rs1, out_rs2, out_funct3}, {5'd1, 5'd2, 3'b010});
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        offer(32'h123452B7);
        check("lui_fmt_rd", {out_fmt, out_rd}, {3'd4, 5'd5});
        check("lui_imm", out_imm, 32'h12345000);
        offer(32'h00000000);
        check("zero_illegal", {out_illegal, out_fmt}, {1'b1, 3'd7});
        offer(32'h0000001B);
        check("opimm32_illegal", {out_illegal, out_fmt, out_imm}, {1'b1, 3'd7, 32'd0});
        cycle();
        check("cnt_illegal_2", cnt_illegal, 2);
        check("cnt_decoded_5", cnt_decoded, 5);

        // Four-instruction stream with out_ready low for three cycles mid-stream.
        stream = '{32'h00100113, 32'h002081B3, 32'hFE000EE3, 32'h0040026F};
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = idx < 4;
            in_inst   = stream[idx % 4];
            if (in_valid && in_ready) idx++;
            cycle();
        end
        in_valid = 1'b0;
        check("stream_accepted", idx, 4);
        check("stream_drained", sb.size(), 0);

        // Flush with valid output and a simultaneous input offer.
        out_ready = 1'b0;
        offer(32'h00A00513);
        in_valid = 1'b1;
        in_inst  = 32'h00B00593;
        cycle();
        snap_dec = cnt_decoded;
        snap_ill = cnt_illegal;
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_cnt", {cnt_decoded, cnt_illegal}, {4'(snap_dec), 4'(snap_ill)});

        // Randomized traffic with occasional flushes and one reset pulse mid-stream.
        for (int c = 0; c < 800; c++) begin
            in_valid  = $urandom_range(3) != 0;
            in_inst   = rand_inst();
            out_ready = $urandom_range(2) != 0;
            flush     = $urandom_range(39) == 0;
            if (c == 400) rst_n = 1'b0;
            if (c == 402) rst_n = 1'b1;
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) cycle();
        check("final_drain", sb.size(), 0);
        check("cnt_saturated", cnt_decoded, CMAX);

        // Reset pulse while data is held on the output.
        out_ready = 1'b0;
        offer(32'h00500093);
        rst_n = 1'b0;
        #2;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_fmt", out_fmt, 7);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RISC-V instruction decode stage; the parametrised successor of the combinational 5-bit opcode-class mapper.
- Accepts a 32-bit instruction word over a valid/ready handshake, then emits:
  - opcode class
  - instruction format
  - register indices and funct fields
  - sign-extended immediate
  - illegal flag
- Sits between fetch and the register-read/execute stage.
- Keeps a saturating count of decoded and illegal instructions.

Parameters:
- XLEN, 32, datapath width for imm; legal values are 32 and 64.
- CNT_W, 16, width of the retired-decode and illegal counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops the held instruction
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_class  out  5  inst[6:2] opcode class
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=NONE
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_funct3  out  3
- out_funct7  out  7
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  instruction not supported
- cnt_decoded  out  CNT_W  handshaked outputs, saturating
- cnt_illegal  out  CNT_W  handshaked illegal outputs, saturating

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, all out_* fields=0, out_fmt=7, counters=0.
  - in_ready=1 in the base build.
- Handshake:
  - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
  - Base build: in_ready = !out_valid | out_ready (combinational).
- Latency:
  - Accepted instruction appears on out_* on the next clock edge with out_valid=1.
  - Full throughput: one instruction per cycle while out_ready=1.
- Hold: while out_valid&!out_ready, every out_* field is held stable.
- Class and format mapping, class = inst[6:2]:
  - LOAD 00000, MISC_MEM 00011, OP_IMM 00100, JALR 11001, SYSTEM 11100 -> I
  - STORE 01000 -> S
  - OP 01100 -> R
  - LUI 01101, AUIPC 00101 -> U
  - BRANCH 11000 -> B
  - JAL 11011 -> J
  - OP_IMM_32 00110 -> I and OP_32 01110 -> R, legal only when XLEN=64
  - Any other class -> fmt 7
- Illegal:
  - out_illegal=1 if inst[1:0]!=2'b11 or fmt would be 7.
  - When illegal: out_fmt=7, out_imm=0; rd/rs/funct still carry raw bit fields.
- Field extraction is always raw: rd=inst[11:7], rs1=inst[19:15], rs2=inst[24:20], funct3=inst[14:12], funct7=inst[31:25].
- Immediates, all sign-extended from inst[31] to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R = 0
- Counters:
  - Increment on each output transfer; cnt_illegal only if out_illegal.
  - Saturate at all-ones; no wrap.
- Flush:
  - At the clock edge, out_valid->0 and any input offered in that cycle is discarded.
  - Counters unchanged; flush wins over simultaneous in and out transfers.
- Reset mid-operation: immediate return to reset values; the in-flight instruction is lost.

Optional Feature:
- Macro: RV_DECODE_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer; in_ready becomes a register (1 at reset).
  - in_ready deasserts only when the skid entry fills, i.e. out_valid&!out_ready and an input accepted.
  - Skid drains into the output register on the next out transfer.
  - Order preserved; throughput still 1/cycle.
  - Flush clears both entries and sets in_ready=1.
- Undefined: combinational in_ready as above; no skid storage.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle:
  - class=00100, fmt=1, rd=1, rs1=0, imm=5, illegal=0, cnt_decoded=1.
- 0xFE20AE23 (sw x2,-4(x1)) -> fmt=2, rs1=1, rs2=2, funct3=010, imm=0xFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) -> fmt=4, rd=5, imm=0x12345000.
- 0x00000000, then 0x0000001B with XLEN=32:
  - both illegal=1, fmt=7; cnt_illegal=2.
  - With XLEN=64, 0x0000001B decodes as OP_IMM_32, fmt=1.
- Stream of 4 instructions with out_ready low for 3 cycles mid-stream -> outputs held stable, no loss or duplication, order preserved. Repeat with RV_DECODE_SKID_EN.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, counters unchanged. Separately, rst_n pulsed low mid-stream -> all outputs at reset values.
